// File: rtl/upsample_pkg.sv
// Shared constants and the default coefficient table for the 2x upsampling
// convolution engine.
//   PIX_W_DEF / FRAC_BITS_DEF : default pixel width and coefficient fraction bits
//   K1D / KR1D                : 1-D interpolation kernels (KR1D is K1D mirrored)
//   default_coef()            : outer-product coefficient for (phase, tap)
package upsample_pkg;

  localparam int unsigned PIX_W_DEF     = 12;
  localparam int unsigned FRAC_BITS_DEF = 14;

  localparam int K1D  [4] = '{-3, 29, 111, -9};
  localparam int KR1D [4] = '{-9, 111, 29, -3};

  // Phase bit 1 selects the mirrored kernel for rows, bit 0 for columns.
  // Each 1-D kernel sums to 128, so every phase sums to 16384 (1.0 in Q14).
  function automatic int default_coef(input int unsigned win,
                                      input int unsigned phases,
                                      input int unsigned p,
                                      input int unsigned tap);
    int unsigned r;
    int unsigned c;
    int          row_k;
    int          col_k;
    if (win != 4 || phases != 4) return 0;
    r     = tap / win;
    c     = tap % win;
    row_k = p[1] ? KR1D[r[1:0]] : K1D[r[1:0]];
    col_k = p[0] ? KR1D[c[1:0]] : K1D[c[1:0]];
    return row_k * col_k;
  endfunction

endpackage

// File: rtl/conv_phase_mac.sv
// One output phase of the upsampling engine: TAPS multipliers (S1), adder
// tree (S2), round/shift/clamp into the output register (S3).
//   clk, rst_n : clock, async active-low reset
//   adv        : pipeline advance (low while the output is stalled)
//   pix        : TAPS unsigned pixels, tap t at [t*PIX_W +: PIX_W]
//   coef       : TAPS signed coefficients, tap t at [t*COEF_W +: COEF_W]
//   y          : clamped result
//   sat        : result was clamped
module conv_phase_mac
  import upsample_pkg::*;
#(
  parameter int unsigned PIX_W     = PIX_W_DEF,
  parameter int unsigned TAPS      = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
  parameter int unsigned ACC_W     = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     adv,
  input  logic [PIX_W*TAPS-1:0]    pix,
  input  logic [COEF_W*TAPS-1:0]   coef,
  output logic [PIX_W-1:0]         y,
  output logic                     sat
);

  localparam int unsigned PROD_W = PIX_W + COEF_W + 1;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << PIX_W) - 1);

  logic signed [PROD_W-1:0] prod_c [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  scaled;
  logic [PIX_W-1:0]         y_c;
  logic                     sat_c;

  // Pixels are zero-extended so the product is a plain signed multiply.
  always_comb begin
    for (int unsigned t = 0; t < TAPS; t++) begin
      prod_c[t] = PROD_W'($signed({1'b0, pix[t*PIX_W +: PIX_W]}))
                * PROD_W'($signed(coef[t*COEF_W +: COEF_W]));
    end
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned t = 0; t < TAPS; t++) begin
      sum_c = sum_c + ACC_W'(prod_q[t]);
    end
  end

  always_comb begin
    scaled = (acc_q + HALF) >>> FRAC_BITS;
    y_c    = '0;
    sat_c  = 1'b0;
    if (scaled < 0) begin
      sat_c = 1'b1;
    end else if (scaled > MAXV) begin
      y_c   = '1;
      sat_c = 1'b1;
    end else begin
      y_c = scaled[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < TAPS; t++) prod_q[t] <= '0;
      acc_q <= '0;
      y     <= '0;
      sat   <= 1'b0;
    end else if (adv) begin
      for (int unsigned t = 0; t < TAPS; t++) prod_q[t] <= prod_c[t];
      acc_q <= sum_c;
      y     <= y_c;
      sat   <= sat_c;
    end
  end

endmodule

// File: rtl/conv_upsample_pipe.sv
// 2x upsampling convolution engine: one WINxWIN window in, PHASES
// interpolated sub-pixels out, 3-stage pipeline with global stall.
//   s_valid/s_ready/s_pixel_data : window input (tap r*WIN+c at [(r*WIN+c)*PIX_W +: PIX_W])
//   m_valid/m_ready/m_pixel_data : result output (phase 0 in the MSB field)
//   m_sat                        : per-phase clamp flags
//   cfg_we/cfg_addr/cfg_wdata    : shadow coefficient write (addr = p*TAPS + tap)
//   cfg_commit                   : copy shadow bank to active bank
module conv_upsample_pipe
  import upsample_pkg::*;
#(
  parameter int unsigned PIX_W     = PIX_W_DEF,
  parameter int unsigned WIN       = 4,
  parameter int unsigned PHASES    = 4,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [PIX_W*WIN*WIN-1:0]             s_pixel_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [PIX_W*PHASES-1:0]              m_pixel_data,
  output logic [PHASES-1:0]                    m_sat,
  input  logic                                 cfg_we,
  input  logic [$clog2(PHASES*WIN*WIN)-1:0]    cfg_addr,
  input  logic [COEF_W-1:0]                    cfg_wdata,
  input  logic                                 cfg_commit
);

  localparam int unsigned TAPS  = WIN * WIN;
  localparam int unsigned NCOEF = PHASES * TAPS;
  localparam int unsigned ACC_W = PIX_W + COEF_W + $clog2(TAPS) + 1;

  logic [COEF_W-1:0] shadow [NCOEF];
  logic [COEF_W-1:0] active [NCOEF];
  logic              adv;
  logic              v1;
  logic              v2;

  assign adv     = ~(m_valid & ~m_ready);
  assign s_ready = adv;

  // Commit reads shadow before the same-cycle write lands (NBA ordering), so
  // a write issued alongside a commit waits for the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCOEF; i++) begin
        shadow[i] <= COEF_W'(default_coef(WIN, PHASES, i / TAPS, i % TAPS));
        active[i] <= COEF_W'(default_coef(WIN, PHASES, i / TAPS, i % TAPS));
      end
    end else begin
      if (cfg_commit) begin
        for (int unsigned i = 0; i < NCOEF; i++) active[i] <= shadow[i];
      end
      if (cfg_we && (32'(cfg_addr) < NCOEF)) shadow[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      m_valid <= 1'b0;
    end else if (adv) begin
      v1      <= s_valid;
      v2      <= v1;
      m_valid <= v2;
    end
  end

  for (genvar p = 0; p < PHASES; p++) begin : g_phase
    logic [COEF_W*TAPS-1:0] coef_row;

    always_comb begin
      coef_row = '0;
      for (int unsigned t = 0; t < TAPS; t++) begin
        coef_row[t*COEF_W +: COEF_W] = active[p*TAPS + t];
      end
    end

    conv_phase_mac #(
      .PIX_W     (PIX_W),
      .TAPS      (TAPS),
      .COEF_W    (COEF_W),
      .FRAC_BITS (FRAC_BITS),
      .ACC_W     (ACC_W)
    ) u_mac (
      .clk  (clk),
      .rst_n(rst_n),
      .adv  (adv),
      .pix  (s_pixel_data),
      .coef (coef_row),
      .y    (m_pixel_data[(PHASES-1-p)*PIX_W +: PIX_W]),
      .sat  (m_sat[p])
    );
  end

endmodule

// File: tb/tb_conv_upsample_pipe.sv
module tb_conv_upsample_pipe;

  localparam int PIX_W  = 12;
  localparam int TAPS   = 16;
  localparam int PHASES = 4;
  localparam int NCOEF  = 64;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic [PIX_W*TAPS-1:0]   s_pixel_data = '0;
  logic                    m_valid;
  logic                    m_ready = 1'b1;
  logic [PIX_W*PHASES-1:0] m_pixel_data;
  logic [PHASES-1:0]       m_sat;
  logic                    cfg_we = 1'b0;
  logic [5:0]              cfg_addr = '0;
  logic [15:0]             cfg_wdata = '0;
  logic                    cfg_commit = 1'b0;

  conv_upsample_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_pixel_data(s_pixel_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_pixel_data(m_pixel_data),
    .m_sat       (m_sat),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_commit  (cfg_commit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] data;
    logic [3:0]  sat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   shadow_m [NCOEF];
  int   active_m [NCOEF];
  int   bp_mode = 0;
  int   bp_cnt = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference coefficients straight from the 1-D kernels.
  function automatic void model_defaults();
    int k  [4] = '{-3, 29, 111, -9};
    int kr [4] = '{-9, 111, 29, -3};
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          int a;
          int b;
          a = (p == 0 || p == 1) ? k[r] : kr[r];
          b = (p == 0 || p == 2) ? k[c] : kr[c];
          shadow_m[p*16 + r*4 + c] = a * b;
          active_m[p*16 + r*4 + c] = a * b;
        end
  endfunction

  function automatic exp_t model(input logic [PIX_W*TAPS-1:0] pix);
    exp_t   e;
    longint acc;
    longint y;
    e = '0;
    for (int p = 0; p < PHASES; p++) begin
      acc = 0;
      for (int t = 0; t < TAPS; t++)
        acc += longint'(active_m[p*16 + t]) * longint'(pix[t*PIX_W +: PIX_W]);
      y = (acc + 8192) >>> 14;
      if (y < 0) begin
        y = 0;
        e.sat[p] = 1'b1;
      end else if (y > 4095) begin
        y = 4095;
        e.sat[p] = 1'b1;
      end
      e.data[(3-p)*PIX_W +: PIX_W] = 12'(y);
    end
    return e;
  endfunction

  function automatic logic [PIX_W*TAPS-1:0] flat(input int v);
    logic [PIX_W*TAPS-1:0] r;
    for (int t = 0; t < TAPS; t++) r[t*PIX_W +: PIX_W] = 12'(v);
    return r;
  endfunction

  function automatic logic [PIX_W*TAPS-1:0] rand_pix();
    logic [PIX_W*TAPS-1:0] r;
    int mode;
    mode = $urandom_range(0, 3);
    for (int t = 0; t < TAPS; t++) begin
      if (mode == 0) r[t*PIX_W +: PIX_W] = ($urandom_range(0, 1) == 1) ? 12'hFFF : 12'h000;
      else           r[t*PIX_W +: PIX_W] = 12'($urandom_range(0, 4095));
    end
    return r;
  endfunction

  // Called and returns at posedge+#1. Config is pulsed on the first cycle
  // only; the beat is held until accepted.
  task automatic drive(input logic [PIX_W*TAPS-1:0] pix, input bit valid,
                       input bit we, input int addr, input int data, input bit commit);
    bit first = 1'b1;
    bit done  = 1'b0;
    int guard = 0;
    while (!done) begin
      s_valid      = valid;
      s_pixel_data = pix;
      cfg_we       = first & we;
      cfg_addr     = 6'(addr);
      cfg_wdata    = 16'(data);
      cfg_commit   = first & commit;
      @(negedge clk);
      if (valid && s_ready) q.push_back(model(pix));
      if (first) begin
        if (commit) active_m = shadow_m;
        if (we) shadow_m[addr] = data;
      end
      done = !valid || s_ready;
      @(posedge clk);
      #1;
      first = 1'b0;
      guard++;
      if (!done && guard > 60) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: beat not accepted within %0d cycles", guard);
        done = 1'b1;
      end
    end
    s_valid    = 1'b0;
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic beat(input logic [PIX_W*TAPS-1:0] pix);
    drive(pix, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_leftover", q.size(), 0);
  endtask

  task automatic latency_flat1000();
    int n = 1;
    beat(flat(1000));
    while (!m_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 3);
  endtask

  // m_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1: begin
          m_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
          bp_cnt++;
        end
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares the presented result against the queue head every
  // cycle it is valid (so held outputs are checked too), pops on transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_ready) check("s_ready_open", s_ready, 1);
        else if (m_valid) check("s_ready_stall", s_ready, 0);
        if (m_valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out: got data %h with empty scoreboard", m_pixel_data);
          end else begin
            check("out_data", m_pixel_data, q[0].data);
            check("out_sat", m_sat, q[0].sat);
            if (m_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [PIX_W*TAPS-1:0] p;
    model_defaults();
    #2;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_pixel_data, 0);
    check("rst_m_sat", m_sat, 0);
    check("rst_s_ready", s_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    latency_flat1000();
    beat(flat(4095));
    // taps carrying the 111 weight zeroed
    for (int t = 0; t < TAPS; t++) p[t*PIX_W +: PIX_W] = (t / 4 == 2 || t % 4 == 2) ? 12'd0 : 12'd4095;
    beat(p);
    // only negatively weighted phase-0 taps set -> clamps low
    for (int t = 0; t < TAPS; t++)
      p[t*PIX_W +: PIX_W] = (((t/4 == 0) || (t/4 == 3)) != ((t%4 == 0) || (t%4 == 3))) ? 12'd4095 : 12'd0;
    beat(p);
    // only the central (positive) taps set -> clamps high
    for (int t = 0; t < TAPS; t++)
      p[t*PIX_W +: PIX_W] = ((t/4 == 1 || t/4 == 2) && (t%4 == 1 || t%4 == 2)) ? 12'd4095 : 12'd0;
    beat(p);
    p = '0;
    p[5*PIX_W +: PIX_W] = 12'd4095;
    beat(p);
    drain();

    bp_mode = 2;
    for (int i = 0; i < 40; i++) drive(rand_pix(), ($urandom_range(0, 3) != 0), 1'b0, 0, 0, 1'b0);
    drain();

    bp_cnt  = 0;
    bp_mode = 1;
    for (int i = 0; i < 8; i++) beat(rand_pix());
    drain();
    bp_mode = 0;

    // phase 0 becomes a pass-through of tap 0 after commit
    for (int t = 0; t < TAPS; t++) drive('0, 1'b0, 1'b1, t, (t == 0) ? 16384 : 0, 1'b0);
    beat(rand_pix());
    drive(rand_pix(), 1'b1, 1'b0, 0, 0, 1'b1);
    beat(rand_pix());
    beat(rand_pix());
    // write together with commit: not active until the following commit
    drive(rand_pix(), 1'b1, 1'b1, 16, 16384, 1'b1);
    beat(rand_pix());
    beat(flat(1000));
    drive('0, 1'b0, 1'b0, 0, 0, 1'b1);
    beat(flat(1000));
    beat(rand_pix());
    drain();

    // reset with three beats in flight
    beat(flat(1000));
    beat(rand_pix());
    beat(rand_pix());
    check("pre_reset_valid", m_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", m_valid, 0);
    check("async_rst_data", m_pixel_data, 0);
    q.delete();
    model_defaults();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_valid", m_valid, 0);
    rst_n = 1'b1;

    latency_flat1000();
    for (int i = 0; i < 6; i++) beat(rand_pix());
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
